// File: rtl/z16_inst_decoder.sv
// Z16 instruction decode stage.
// Takes 16-bit instruction words over valid/ready, joins the two words of an
// LIW instruction, and presents one registered decoded op per instruction to
// the ALU issue interface. ALU operand A = R[rs1], B = use_imm ? imm : R[rs2].
module z16_inst_decoder #(
  parameter bit IMM8_SIGNED = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_instr_valid,
  input  logic [15:0]      i_instr,
  output logic             o_instr_ready,
  output logic             o_dec_valid,
  input  logic             i_dec_ready,
  output logic [3:0]       o_alu_ctrl,
  output logic [3:0]       o_rd,
  output logic [3:0]       o_rs1,
  output logic [3:0]       o_rs2,
  output logic [15:0]      o_imm,
  output logic             o_use_imm,
  output logic             o_wr_en,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_dec_count
);

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_EXT = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LIW  = 4'hA;
  localparam logic [3:0] CTRL_OR = 4'h4;

  state_t           state_r;
  logic [3:0]       pend_rd_r;
  logic             dec_valid_r;
  logic [3:0]       alu_ctrl_r;
  logic [3:0]       rd_r;
  logic [3:0]       rs1_r;
  logic [3:0]       rs2_r;
  logic [15:0]      imm_r;
  logic             use_imm_r;
  logic             wr_en_r;
  logic             illegal_r;
  logic [CNT_W-1:0] dec_count_r;

  logic             free_s;
  logic             accept_s;
  logic             drain_s;
  logic [3:0]       op_s;
  logic [15:0]      imm8_ext_s;
  logic             start_liw_s;
  logic [3:0]       nxt_ctrl_s;
  logic [3:0]       nxt_rd_s;
  logic [3:0]       nxt_rs1_s;
  logic [3:0]       nxt_rs2_s;
  logic [15:0]      nxt_imm_s;
  logic             nxt_use_imm_s;
  logic             nxt_wr_en_s;
  logic             nxt_illegal_s;

  // The output slot can take a new op when it is empty or being drained now.
  assign free_s        = !dec_valid_r || i_dec_ready;
  assign o_instr_ready = free_s && !i_flush && !i_rst;
  assign accept_s      = i_instr_valid && o_instr_ready;
  assign drain_s       = dec_valid_r && i_dec_ready;
  assign op_s          = i_instr[3:0];
  assign start_liw_s   = (state_r == S_OP) && (op_s == OP_LIW);

  // Extend the ADDI immediate according to the configured signedness.
  always_comb begin
    imm8_ext_s = 16'h0000;
    if (IMM8_SIGNED) begin
      imm8_ext_s = {{8{i_instr[15]}}, i_instr[15:8]};
    end else begin
      imm8_ext_s = {8'h00, i_instr[15:8]};
    end
  end

  // Decode the word at the input into the op that would be loaded on accept.
  always_comb begin
    nxt_ctrl_s    = 4'h0;
    nxt_rd_s      = 4'h0;
    nxt_rs1_s     = 4'h0;
    nxt_rs2_s     = 4'h0;
    nxt_imm_s     = 16'h0000;
    nxt_use_imm_s = 1'b0;
    nxt_wr_en_s   = 1'b0;
    nxt_illegal_s = 1'b0;
    case (state_r)
      S_EXT: begin
        // Second LIW word: OR r0 with the full 16-bit immediate.
        nxt_ctrl_s    = CTRL_OR;
        nxt_rd_s      = pend_rd_r;
        nxt_imm_s     = i_instr;
        nxt_use_imm_s = 1'b1;
        nxt_wr_en_s   = 1'b1;
      end
      S_OP: begin
        if (op_s <= 4'h8) begin
          nxt_ctrl_s  = op_s;
          nxt_rd_s    = i_instr[7:4];
          nxt_rs1_s   = i_instr[11:8];
          nxt_rs2_s   = i_instr[15:12];
          nxt_wr_en_s = 1'b1;
        end else if (op_s == OP_ADDI) begin
          nxt_rd_s      = i_instr[7:4];
          nxt_rs1_s     = i_instr[7:4];
          nxt_imm_s     = imm8_ext_s;
          nxt_use_imm_s = 1'b1;
          nxt_wr_en_s   = 1'b1;
        end else if (op_s == OP_LIW) begin
          // First LIW word never loads the output; fields are unused.
          nxt_rd_s = i_instr[7:4];
        end else begin
          nxt_illegal_s = 1'b1;
        end
      end
      default: begin
        nxt_illegal_s = 1'b0;
      end
    endcase
  end

  // FSM, pending LIW destination, output register and retired-op counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= S_OP;
      pend_rd_r   <= 4'h0;
      dec_valid_r <= 1'b0;
      alu_ctrl_r  <= 4'h0;
      rd_r        <= 4'h0;
      rs1_r       <= 4'h0;
      rs2_r       <= 4'h0;
      imm_r       <= 16'h0000;
      use_imm_r   <= 1'b0;
      wr_en_r     <= 1'b0;
      illegal_r   <= 1'b0;
      dec_count_r <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      // Flush kills the output and any half-assembled LIW; count is kept.
      state_r     <= S_OP;
      pend_rd_r   <= 4'h0;
      dec_valid_r <= 1'b0;
    end else begin
      if (drain_s) begin
        dec_count_r <= dec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        if (start_liw_s) begin
          state_r     <= S_EXT;
          pend_rd_r   <= nxt_rd_s;
          dec_valid_r <= 1'b0;
        end else begin
          state_r     <= S_OP;
          dec_valid_r <= 1'b1;
          alu_ctrl_r  <= nxt_ctrl_s;
          rd_r        <= nxt_rd_s;
          rs1_r       <= nxt_rs1_s;
          rs2_r       <= nxt_rs2_s;
          imm_r       <= nxt_imm_s;
          use_imm_r   <= nxt_use_imm_s;
          wr_en_r     <= nxt_wr_en_s;
          illegal_r   <= nxt_illegal_s;
        end
      end else if (i_dec_ready) begin
        dec_valid_r <= 1'b0;
      end
    end
  end

  assign o_dec_valid = dec_valid_r;
  assign o_alu_ctrl  = alu_ctrl_r;
  assign o_rd        = rd_r;
  assign o_rs1       = rs1_r;
  assign o_rs2       = rs2_r;
  assign o_imm       = imm_r;
  assign o_use_imm   = use_imm_r;
  assign o_wr_en     = wr_en_r;
  assign o_illegal   = illegal_r;
  assign o_dec_count = dec_count_r;

endmodule

// File: tb/tb_z16_inst_decoder.sv
// Self-checking bench for z16_inst_decoder: directed scenarios plus a random
// instruction stream checked against a transaction-level decode model.
module tb_z16_inst_decoder;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        use_imm;
    logic        wr_en;
    logic        illegal;
  } op_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic [15:0] i_instr = 16'h0000;
  logic        i_dec_ready = 1'b0;

  logic        o_instr_ready, o_dec_valid, o_use_imm, o_wr_en, o_illegal;
  logic [3:0]  o_alu_ctrl, o_rd, o_rs1, o_rs2;
  logic [15:0] o_imm;
  logic [15:0] o_dec_count;

  logic        r2_instr_ready, r2_dec_valid, r2_use_imm, r2_wr_en, r2_illegal;
  logic [3:0]  r2_alu_ctrl, r2_rd, r2_rs1, r2_rs2;
  logic [15:0] r2_imm;
  logic [3:0]  r2_dec_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;

  always #5 i_clk = ~i_clk;

  z16_inst_decoder #(.IMM8_SIGNED(1'b1), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr),
    .o_instr_ready(o_instr_ready), .o_dec_valid(o_dec_valid),
    .i_dec_ready(i_dec_ready), .o_alu_ctrl(o_alu_ctrl), .o_rd(o_rd),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_use_imm(o_use_imm),
    .o_wr_en(o_wr_en), .o_illegal(o_illegal), .o_dec_count(o_dec_count)
  );

  z16_inst_decoder #(.IMM8_SIGNED(1'b0), .CNT_W(4)) dut_u (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr),
    .o_instr_ready(r2_instr_ready), .o_dec_valid(r2_dec_valid),
    .i_dec_ready(i_dec_ready), .o_alu_ctrl(r2_alu_ctrl), .o_rd(r2_rd),
    .o_rs1(r2_rs1), .o_rs2(r2_rs2), .o_imm(r2_imm), .o_use_imm(r2_use_imm),
    .o_wr_en(r2_wr_en), .o_illegal(r2_illegal), .o_dec_count(r2_dec_count)
  );

  function automatic op_t mkop(input logic [3:0] c, input logic [3:0] d,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [15:0] im, input logic u,
                               input logic w, input logic il);
    op_t o;
    o.ctrl = c; o.rd = d; o.rs1 = a; o.rs2 = b; o.imm = im;
    o.use_imm = u; o.wr_en = w; o.illegal = il;
    return o;
  endfunction

  function automatic op_t obs();
    return mkop(o_alu_ctrl, o_rd, o_rs1, o_rs2, o_imm, o_use_imm, o_wr_en, o_illegal);
  endfunction

  function automatic op_t obs_u();
    return mkop(r2_alu_ctrl, r2_rd, r2_rs1, r2_rs2, r2_imm, r2_use_imm, r2_wr_en, r2_illegal);
  endfunction

  // Reference meaning of a single-word instruction (signed ADDI immediate).
  function automatic op_t ref_single(input logic [15:0] w);
    int op;
    int imm8;
    int imm;
    op = int'(w[3:0]);
    imm8 = int'(w[15:8]);
    if (op <= 8) return mkop(w[3:0], w[7:4], w[11:8], w[15:12], 16'h0000, 1'b0, 1'b1, 1'b0);
    if (op == 9) begin
      imm = (imm8 >= 128) ? (imm8 - 256) : imm8;
      return mkop(4'h0, w[7:4], w[7:4], 4'h0, 16'(imm), 1'b1, 1'b1, 1'b0);
    end
    return mkop(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1);
  endfunction

  // Apply inputs for the next rising edge and account for an expected handshake.
  task automatic drive(input logic rst, input logic v, input logic [15:0] w,
                       input logic dr, input logic fl);
    i_rst = rst; i_instr_valid = v; i_instr = w; i_dec_ready = dr; i_flush = fl;
    #1;
    if (rst) exp_count = 32'd0;
    else if (!fl && o_dec_valid && dr) exp_count = exp_count + 32'd1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic step(input logic rst, input logic v, input logic [15:0] w,
                      input logic dr, input logic fl);
    drive(rst, v, w, dr, fl);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 16'h2130, 1'b1, 1'b0);
    checks++;
    if (o_instr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", o_instr_ready);
    end
    tick();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b0 || obs() !== op_t'(0) || o_dec_count !== 16'h0000) begin
      errors++; $display("FAIL reset_state: got v=%b op=%h cnt=%h want v=0 op=0 cnt=0",
                         o_dec_valid, obs(), o_dec_count);
    end
  endtask

  task automatic test_rtype();
    step(1'b0, 1'b1, 16'h2130, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h0, 4'h3, 4'h1, 4'h2, 16'h0, 1'b0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rtype_add: got v=%b op=%h", o_dec_valid, obs());
    end
  endtask

  task automatic test_addi();
    step(1'b0, 1'b1, 16'hFE59, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h0, 4'h5, 4'h5, 4'h0, 16'hFFFE, 1'b1, 1'b1, 1'b0)) begin
      errors++; $display("FAIL addi_signed: got v=%b op=%h", o_dec_valid, obs());
    end
    checks++;
    if (r2_dec_valid !== 1'b1 || obs_u() !== mkop(4'h0, 4'h5, 4'h5, 4'h0, 16'h00FE, 1'b1, 1'b1, 1'b0)) begin
      errors++; $display("FAIL addi_unsigned: got v=%b op=%h", r2_dec_valid, obs_u());
    end
  endtask

  task automatic test_liw();
    step(1'b0, 1'b1, 16'h007A, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b0) begin
      errors++; $display("FAIL liw_word1: got v=%b want 0", o_dec_valid);
    end
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h4, 4'h7, 4'h0, 4'h0, 16'h1234, 1'b1, 1'b1, 1'b0)) begin
      errors++; $display("FAIL liw_word2: got v=%b op=%h", o_dec_valid, obs());
    end
  endtask

  task automatic test_stall();
    op_t held;
    held = mkop(4'h4, 4'h7, 4'h0, 4'h0, 16'h1234, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 16'h0017, 1'b0, 1'b0);
      checks++;
      if (o_instr_ready !== 1'b0 || r2_instr_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready: got %b/%b want 0", o_instr_ready, r2_instr_ready);
      end
      tick();
      checks++;
      if (o_dec_valid !== 1'b1 || obs() !== held) begin
        errors++; $display("FAIL stall_hold: got v=%b op=%h want op=%h", o_dec_valid, obs(), held);
      end
    end
    drive(1'b0, 1'b1, 16'h0017, 1'b1, 1'b0);
    checks++;
    if (o_instr_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %b want 1", o_instr_ready);
    end
    tick();
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h7, 4'h1, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL stall_shl: got v=%b op=%h", o_dec_valid, obs());
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 16'h007A, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'h2130, 1'b1, 1'b1);
    checks++;
    if (o_instr_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", o_instr_ready);
    end
    tick();
    step(1'b0, 1'b1, 16'h2130, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h0, 4'h3, 4'h1, 4'h2, 16'h0, 1'b0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL flush_liw_dropped: got v=%b op=%h", o_dec_valid, obs());
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checks++;
    if (o_dec_valid !== 1'b0 || o_dec_count !== exp_count[15:0]) begin
      errors++; $display("FAIL flush_count: got v=%b cnt=%h want v=0 cnt=%h",
                         o_dec_valid, o_dec_count, exp_count[15:0]);
    end
    step(1'b0, 1'b1, 16'h000F, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL illegal_op: got v=%b op=%h", o_dec_valid, obs());
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_liw();
    step(1'b0, 1'b1, 16'h00BA, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h2130, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b1 || obs() !== mkop(4'h0, 4'h3, 4'h1, 4'h2, 16'h0, 1'b0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL reset_mid_liw: got v=%b op=%h", o_dec_valid, obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h2130; words[1] = 16'h5461; words[2] = 16'h9872;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, words[k], 1'b1, 1'b0);
      checks++;
      if (o_instr_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready: word %0d got %b want 1", k, o_instr_ready);
      end
      tick();
      checks++;
      if (o_dec_valid !== 1'b1 || obs() !== ref_single(words[k])) begin
        errors++; $display("FAIL b2b_op: word %0d got v=%b op=%h want %h",
                           k, o_dec_valid, obs(), ref_single(words[k]));
      end
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (o_dec_valid !== 1'b0 || o_dec_count !== 16'd3 || r2_dec_count !== 4'd3) begin
      errors++; $display("FAIL b2b_count: got v=%b cnt=%0d/%0d want v=0 cnt=3",
                         o_dec_valid, o_dec_count, r2_dec_count);
    end
  endtask

  task automatic test_count_wrap();
    int guard;
    guard = 0;
    while (exp_count != 32'h0000FFFF && guard < 70000) begin
      step(1'b0, 1'b1, 16'h2130, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (o_dec_count !== 16'hFFFF || r2_dec_count !== 4'hF || exp_count != 32'h0000FFFF) begin
      errors++; $display("FAIL count_max: got %h/%h want FFFF/F", o_dec_count, r2_dec_count);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (o_dec_count !== 16'h0000 || r2_dec_count !== 4'h0) begin
      errors++; $display("FAIL count_wrap: got %h/%h want 0/0", o_dec_count, r2_dec_count);
    end
  endtask

  task automatic test_random();
    logic [15:0] words [$];
    op_t         exp_q [$];
    op_t         held;
    op_t         want;
    logic [15:0] w;
    logic        v, dr, hold_pending;
    int          idx, cyc;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    while (words.size() < 400) begin
      w = 16'($urandom);
      words.push_back(w);
      if (w[3:0] == 4'hA) begin
        words.push_back(16'($urandom));
        exp_q.push_back(mkop(4'h4, w[7:4], 4'h0, 4'h0, words[words.size()-1], 1'b1, 1'b1, 1'b0));
      end else begin
        exp_q.push_back(ref_single(w));
      end
    end
    idx = 0; cyc = 0; hold_pending = 1'b0; held = op_t'(0);
    while ((idx < words.size() || exp_q.size() > 0) && cyc < 5000) begin
      v  = (idx < words.size()) && ($urandom_range(0, 3) != 0);
      w  = v ? words[idx] : 16'($urandom);
      dr = ($urandom_range(0, 2) != 0);
      drive(1'b0, v, w, dr, 1'b0);
      checks++;
      if (o_instr_ready !== (!o_dec_valid || dr)) begin
        errors++; $display("FAIL rnd_ready: cyc %0d got %b dv=%b dr=%b", cyc, o_instr_ready, o_dec_valid, dr);
      end
      if (hold_pending) begin
        checks++;
        if (o_dec_valid !== 1'b1 || obs() !== held) begin
          errors++; $display("FAIL rnd_stable: cyc %0d got v=%b op=%h want %h", cyc, o_dec_valid, obs(), held);
        end
      end
      if (o_dec_valid && dr) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : op_t'(0);
        checks++;
        if (obs() !== want) begin
          errors++; $display("FAIL rnd_op: cyc %0d got %h want %h", cyc, obs(), want);
        end
      end
      hold_pending = o_dec_valid && !dr;
      held = obs();
      if (v && o_instr_ready) idx++;
      tick();
      cyc++;
    end
    checks++;
    if (idx < words.size() || exp_q.size() > 0) begin
      errors++; $display("FAIL rnd_timeout: consumed %0d of %0d words, %0d ops outstanding",
                         idx, words.size(), exp_q.size());
    end
    checks++;
    if (o_dec_count !== exp_count[15:0] || r2_dec_count !== exp_count[3:0]) begin
      errors++; $display("FAIL rnd_count: got %h/%h want %h", o_dec_count, r2_dec_count, exp_count[15:0]);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_rtype();
    test_addi();
    test_liw();
    test_stall();
    test_flush();
    test_reset_mid_liw();
    test_back_to_back();
    test_random();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
